// File: rtl/led_status_ctrl.sv
// Memory-mapped status-LED controller: per-channel software, heartbeat,
// stretched-activity or PWM source, with a small firmware register file.
module led_status_ctrl #(
    parameter int unsigned           NUM_LEDS       = 4,
    parameter int unsigned           HB_BIT         = 23,
    parameter int unsigned           STRETCH_CYCLES = 5000000,
    parameter int unsigned           PWM_BITS       = 8,
    parameter bit                    ACTIVE_LOW     = 1'b0,
    parameter logic [2*NUM_LEDS-1:0] RESET_MODE     = {NUM_LEDS{2'b01}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                rstrb,
    output logic [31:0]         rdata,
    input  logic [NUM_LEDS-1:0] act_in,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned MW  = 2 * NUM_LEDS;
    localparam int unsigned HBW = HB_BIT + 1;
    localparam int unsigned SW  = $clog2(STRETCH_CYCLES + 1);

    localparam logic [SW-1:0]       STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [NUM_LEDS-1:0] LED_OFF      = {NUM_LEDS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_SW  = 2'b00,
        MODE_HB  = 2'b01,
        MODE_ACT = 2'b10,
        MODE_PWM = 2'b11
    } led_mode_e;

    logic [MW-1:0]                mode_q, mode_d;
    logic [NUM_LEDS-1:0]          level_q, level_d;
    logic [PWM_BITS-1:0]          duty_q, duty_d;
    logic [15:0]                  evcnt_q, evcnt_d;
    logic [HBW-1:0]               hb_cnt_q, hb_cnt_d;
    logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0][SW-1:0]  stretch_q, stretch_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [NUM_LEDS-1:0]          led_q, led_d;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] wmask;
    logic        pwm_lvl;
    logic        unused_bits;

    assign wr_en = sel && (|wstrb);
    assign rd_en = sel && rstrb;
    assign wmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign pwm_lvl = pwm_cnt_q < duty_q;
    assign unused_bits = ^{wdata, wmask};

    always_comb begin
        mode_d    = mode_q;
        level_d   = level_q;
        duty_d    = duty_q;
        evcnt_d   = evcnt_q;
        hb_cnt_d  = hb_cnt_q + HBW'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        rdata_d   = rdata_q;
        stretch_d = stretch_q;
        led_d     = LED_OFF;

        if (wr_en && addr == 2'd0)
            mode_d = (mode_q & ~wmask[MW-1:0]) | (wdata[MW-1:0] & wmask[MW-1:0]);
        if (wr_en && addr == 2'd1)
            level_d = (level_q & ~wmask[NUM_LEDS-1:0])
                    | (wdata[NUM_LEDS-1:0] & wmask[NUM_LEDS-1:0]);
        if (wr_en && addr == 2'd2)
            duty_d = (duty_q & ~wmask[PWM_BITS-1:0])
                   | (wdata[PWM_BITS-1:0] & wmask[PWM_BITS-1:0]);

        // Write-clear wins over a same-cycle event
        if (wr_en && addr == 2'd3)
            evcnt_d = 16'd0;
        else if (|act_in)
            evcnt_d = evcnt_q + 16'd1;

        if (rd_en) begin
            unique case (addr)
                2'd0: rdata_d = 32'(mode_q);
                2'd1: rdata_d = 32'(level_q);
                2'd2: rdata_d = 32'(duty_q);
                2'd3: rdata_d = 32'(evcnt_q);
            endcase
        end

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (act_in[i])
                stretch_d[i] = STRETCH_LOAD;
            else if (stretch_q[i] != '0)
                stretch_d[i] = stretch_q[i] - SW'(1);

            unique case (led_mode_e'(mode_q[2*i +: 2]))
                MODE_SW:  led_d[i] = level_q[i] ^ ACTIVE_LOW;
                MODE_HB:  led_d[i] = hb_cnt_q[HB_BIT] ^ ACTIVE_LOW;
                MODE_ACT: led_d[i] = (stretch_q[i] != '0) ^ ACTIVE_LOW;
                MODE_PWM: led_d[i] = pwm_lvl ^ ACTIVE_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= RESET_MODE;
            level_q   <= '0;
            duty_q    <= '0;
            evcnt_q   <= '0;
            hb_cnt_q  <= '0;
            pwm_cnt_q <= '0;
            stretch_q <= '0;
            rdata_q   <= '0;
            led_q     <= LED_OFF;
        end else begin
            mode_q    <= mode_d;
            level_q   <= level_d;
            duty_q    <= duty_d;
            evcnt_q   <= evcnt_d;
            hb_cnt_q  <= hb_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            stretch_q <= stretch_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
        end
    end

    assign rdata = rdata_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: directed plan plus random traffic, every
// edge compared against a cycle-index reference model.
module tb_led_status_ctrl;

    localparam int N  = 4;
    localparam int HB = 3;
    localparam int S  = 5;
    localparam int PB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rstrb;
    logic [31:0] rdata, rdata_al;
    logic [3:0]  act_in;
    logic [3:0]  led, led_al;

    always #5 clk = ~clk;

    led_status_ctrl #(
        .NUM_LEDS(N), .HB_BIT(HB), .STRETCH_CYCLES(S),
        .PWM_BITS(PB), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata),
        .act_in(act_in), .led(led)
    );

    led_status_ctrl #(
        .NUM_LEDS(N), .HB_BIT(HB), .STRETCH_CYCLES(S),
        .PWM_BITS(PB), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata_al),
        .act_in(act_in), .led(led_al)
    );

    // Reference model: e = edges since reset release
    int          e;
    logic [31:0] m_mode, m_level, m_duty, m_ev, m_rd;
    int          last_act[N];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%h expected=%h",
                   tag, e, obs, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_mode = 32'h55;
        m_level = 0;
        m_duty = 0;
        m_ev = 0;
        m_rd = 0;
        for (int i = 0; i < N; i++) last_act[i] = -1000;
    endtask

    function automatic logic m_src(input int i);
        int md;
        md = int'((m_mode >> (2 * i)) & 3);
        case (md)
            0: return m_level[i];
            1: return (e % (1 << (HB + 1))) >= (1 << HB);
            2: return (e - last_act[i]) <= S;
            default: return (e % (1 << PB)) < int'(m_duty);
        endcase
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0: return m_mode;
            2'd1: return m_level;
            2'd2: return m_duty;
            default: return m_ev;
        endcase
    endfunction

    task automatic step();
        logic [3:0]  exp_led;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic        wr;
        for (int i = 0; i < N; i++) exp_led[i] = m_src(i);
        exp_rd = (sel && rstrb) ? m_reg(addr) : m_rd;
        @(posedge clk);
        wr = sel && (wstrb != 4'd0);
        for (int b = 0; b < 32; b++) mask[b] = wstrb[b / 8];
        if (wr) begin
            case (addr)
                2'd0: m_mode  = ((m_mode  & ~mask) | (wdata & mask)) & 32'hFF;
                2'd1: m_level = ((m_level & ~mask) | (wdata & mask)) & 32'hF;
                2'd2: m_duty  = ((m_duty  & ~mask) | (wdata & mask)) & 32'hFF;
                default: m_ev = 0;
            endcase
        end
        if (!(wr && addr == 2'd3) && act_in != 4'd0)
            m_ev = (m_ev + 1) % 65536;
        for (int i = 0; i < N; i++) if (act_in[i]) last_act[i] = e;
        m_rd = exp_rd;
        e++;
        #1;
        chk("led", {28'd0, led}, {28'd0, exp_led});
        chk("led_al", {28'd0, led_al}, {28'd0, ~exp_led});
        chk("rdata", rdata, exp_rd);
        chk("rdata_al", rdata_al, exp_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        sel = 1'b1; addr = a; wdata = d; wstrb = s;
        step();
        sel = 1'b0; wstrb = 4'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        sel = 1'b1; addr = a; rstrb = 1'b1;
        step();
        sel = 1'b0; rstrb = 1'b0;
        v = rdata;
    endtask

    task automatic count_led(input int n, input int ch, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (led[ch]) hi++;
        end
    endtask

    initial begin
        logic [31:0] v;
        int hi;

        rst_n = 1'b0; sel = 1'b0; addr = 2'd0; wdata = '0;
        wstrb = 4'd0; rstrb = 1'b0; act_in = 4'd0;
        model_reset();
        #12;
        chk("rst_led", {28'd0, led}, 32'h0);
        chk("rst_led_al", {28'd0, led_al}, 32'hF);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Heartbeat: 8 low then 8 high
        count_led(8, 0, hi);
        chk("hb_low", hi, 0);
        count_led(8, 0, hi);
        chk("hb_high", hi, 8);
        count_led(16, 0, hi);
        chk("hb_period", hi, 8);

        rd(2'd0, v);
        chk("mode_reset", v, 32'h55);
        rd(2'd3, v);
        chk("ev_reset", v, 32'h0);

        // Software mode on channel 0
        wr(2'd1, 32'h1, 4'hF);
        wr(2'd0, 32'h54, 4'h1);
        step();
        chk("sw_level", {31'd0, led[0]}, 32'h1);

        // Activity stretch and retrigger
        wr(2'd0, 32'hAA, 4'h1);
        act_in = 4'b0010;
        step();
        act_in = 4'd0;
        count_led(10, 1, hi);
        chk("act_stretch", hi, 5);
        wr(2'd3, 32'h1, 4'h1);
        hi = 0;
        act_in = 4'b0010; step(); if (led[1]) hi++;
        act_in = 4'd0;    step(); if (led[1]) hi++;
        step(); if (led[1]) hi++;
        act_in = 4'b0010; step(); if (led[1]) hi++;
        act_in = 4'd0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (led[1]) hi++;
        end
        chk("act_retrig", hi, 8);
        rd(2'd3, v);
        chk("ev_two", v, 32'h2);

        // PWM duty sweep
        wr(2'd0, 32'hFF, 4'h1);
        wr(2'd2, 32'd64, 4'h1);
        count_led(256, 0, hi);
        chk("pwm_64", hi, 64);
        count_led(256, 3, hi);
        chk("pwm_64_ch3", hi, 64);
        wr(2'd2, 32'd0, 4'h1);
        count_led(256, 0, hi);
        chk("pwm_0", hi, 0);
        wr(2'd2, 32'd255, 4'h1);
        count_led(256, 2, hi);
        chk("pwm_255", hi, 255);

        // Byte strobes and EVCNT boundaries
        wr(2'd1, 32'hFFFF_FFFF, 4'b0001);
        rd(2'd1, v);
        chk("level_strb", v, 32'hF);
        wr(2'd2, 32'h0000_AB00, 4'b0010);
        rd(2'd2, v);
        chk("duty_hi_byte", v, 32'hFF);
        wr(2'd3, 32'h0, 4'b1000);
        act_in = 4'b0001;
        for (int k = 0; k < 65535; k++) step();
        act_in = 4'd0;
        rd(2'd3, v);
        chk("ev_max", v, 32'hFFFF);
        act_in = 4'b0100;
        step();
        act_in = 4'd0;
        rd(2'd3, v);
        chk("ev_wrap", v, 32'h0);
        act_in = 4'b0011;
        step();
        wr(2'd3, 32'h0, 4'b0100);
        act_in = 4'd0;
        rd(2'd3, v);
        chk("ev_clr_prio", v, 32'h0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            sel   = ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            rstrb = $urandom_range(0, 1) == 1;
            for (int i = 0; i < N; i++)
                act_in[i] = ($urandom_range(0, 7) == 0);
            step();
        end
        sel = 1'b0; wstrb = 4'd0; rstrb = 1'b0; act_in = 4'd0;

        // Reset in the middle of a stretch
        wr(2'd0, 32'hAA, 4'h1);
        act_in = 4'hF;
        step();
        act_in = 4'd0;
        step();
        chk("pre_rst_act", {28'd0, led}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_led", {28'd0, led}, 32'h0);
        chk("midrst_led_al", {28'd0, led_al}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        rd(2'd0, v);
        chk("mode_after_rst", v, 32'h55);
        wr(2'd0, 32'hAA, 4'h1);
        step();
        chk("no_residual", {28'd0, led}, 32'h0);
        step();
        chk("no_residual2", {28'd0, led}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
